// File: rtl/speed_button_conditioner.sv
// ---------------------------------------------------------------------------
// speed_button_conditioner
//
// Input conditioning for the two desired-speed push-buttons (add, subtract)
// that feed the cruise-control core. Each raw active-low button is passed
// through a two-flop synchronizer, then debounced. A per-channel FSM turns
// the debounced press into one-clock increment/decrement request pulses,
// with optional hold-to-repeat. Both buttons held together locks out both
// channels until both are released.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   -> holding a button produces a first pulse, a repeat after
//                REPEAT_DELAY, then a repeat every REPEAT_RATE clocks.
//   undefined -> exactly one pulse per press; no repeat state or timer.
//
// Ports:
//   clk          system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   i_add_btn_n  raw add button, 0 = pressed, asynchronous
//   i_sub_btn_n  raw subtract button, 0 = pressed, asynchronous
//   o_add_db_n   debounced add level, 0 = pressed
//   o_sub_db_n   debounced subtract level, 0 = pressed
//   o_add_req    one-clock pulse: desired speed +1
//   o_sub_req    one-clock pulse: desired speed -1
//   o_conflict   high while both channels are locked out
// ---------------------------------------------------------------------------
module speed_button_conditioner #(
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 12500000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_add_btn_n,
  input  logic i_sub_btn_n,
  output logic o_add_db_n,
  output logic o_sub_db_n,
  output logic o_add_req,
  output logic o_sub_req,
  output logic o_conflict
);

  // Channel index 0 is add, index 1 is subtract throughout.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } chanState_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    LOCK  = 2'd3
  } chanState_t;

  // Repeat timing parameters have no hardware in the single-shot build.
  logic w_unusedRepeatCfg;
  assign w_unusedRepeatCfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  logic [1:0]       w_raw;
  logic [1:0]       r_q1;
  logic [1:0]       r_q2;
  logic [1:0]       r_db;
  logic [CNT_W-1:0] r_dbCnt [2];
  logic [1:0]       r_dbPrev;
  logic [1:0]       r_req;
  logic             r_conflict;
  chanState_t       r_state [2];
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] r_timer [2];
`endif

  logic [1:0] w_fall;
  logic       w_bothLow;
  logic       w_bothHigh;

  assign w_raw      = {i_sub_btn_n, i_add_btn_n};
  assign w_fall     = r_dbPrev & ~r_db;
  assign w_bothLow  = ~r_db[0] & ~r_db[1];
  assign w_bothHigh = r_db[0] & r_db[1];

  // Synchronize the raw buttons, then only accept a new level once the
  // synchronized value has disagreed with the debounced level for
  // DB_CYCLES consecutive clocks; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '1;
      r_q2 <= '1;
      r_db <= '1;
      for (int i = 0; i < 2; i++) begin
        r_dbCnt[i] <= '0;
      end
    end else begin
      r_q1 <= w_raw;
      r_q2 <= r_q1;
      for (int i = 0; i < 2; i++) begin
        if (r_q2[i] != r_db[i]) begin
          if (r_dbCnt[i] == DB_LAST) begin
            r_db[i]    <= r_q2[i];
            r_dbCnt[i] <= '0;
          end else begin
            r_dbCnt[i] <= r_dbCnt[i] + CNT_W'(1);
          end
        end else begin
          r_dbCnt[i] <= '0;
        end
      end
    end
  end

  // Request FSMs for both channels. Both-pressed forces a shared LOCK that
  // overrides any pulse due in the same cycle, and LOCK is only left once
  // both buttons are released, so a button still held after its partner
  // lets go stays silent. Release beats a same-cycle timer expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbPrev   <= '1;
      r_req      <= '0;
      r_conflict <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= IDLE;
`ifdef AUTO_REPEAT_EN
        r_timer[i] <= '0;
`endif
      end
    end else begin
      r_dbPrev <= r_db;
      r_req    <= '0;
      if (w_bothLow) begin
        r_conflict <= 1'b1;
        for (int i = 0; i < 2; i++) begin
          r_state[i] <= LOCK;
`ifdef AUTO_REPEAT_EN
          r_timer[i] <= '0;
`endif
        end
      end else if (r_conflict) begin
        if (w_bothHigh) begin
          r_conflict <= 1'b0;
          for (int i = 0; i < 2; i++) begin
            r_state[i] <= IDLE;
          end
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          case (r_state[i])
            IDLE: begin
              if (w_fall[i]) begin
                r_req[i]   <= 1'b1;
                r_state[i] <= DELAY;
`ifdef AUTO_REPEAT_EN
                r_timer[i] <= '0;
`endif
              end
            end
`ifdef AUTO_REPEAT_EN
            DELAY: begin
              if (r_db[i]) begin
                r_state[i] <= IDLE;
                r_timer[i] <= '0;
              end else if (r_timer[i] == RD_LAST) begin
                r_req[i]   <= 1'b1;
                r_timer[i] <= '0;
                r_state[i] <= REPEAT;
              end else begin
                r_timer[i] <= r_timer[i] + CNT_W'(1);
              end
            end
            REPEAT: begin
              if (r_db[i]) begin
                r_state[i] <= IDLE;
                r_timer[i] <= '0;
              end else if (r_timer[i] == RR_LAST) begin
                r_req[i]   <= 1'b1;
                r_timer[i] <= '0;
              end else begin
                r_timer[i] <= r_timer[i] + CNT_W'(1);
              end
            end
`else
            DELAY: begin
              if (r_db[i]) begin
                r_state[i] <= IDLE;
              end
            end
`endif
            default: begin
              r_state[i] <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign o_add_db_n = r_db[0];
  assign o_sub_db_n = r_db[1];
  assign o_add_req  = r_req[0];
  assign o_sub_req  = r_req[1];
  assign o_conflict = r_conflict;

endmodule

// File: tb/tb_speed_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_speed_button_conditioner
//
// Directed bench for speed_button_conditioner with DB_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=8. Edge numbering: a button change is
// applied just after a clock edge; the next rising edge is edge 0 and the
// outputs are sampled 1 time unit after each edge. Expected pulse patterns
// follow the AUTO_REPEAT_EN build setting.
// ---------------------------------------------------------------------------
module tb_speed_button_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;

  logic clk;
  logic rst_n;
  logic addBtnN;
  logic subBtnN;
  logic addDbN;
  logic subDbN;
  logic addReq;
  logic subReq;
  logic conflict;

  int checkCount;
  int passCount;

  speed_button_conditioner #(
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .CNT_W       (26)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_add_btn_n(addBtnN),
    .i_sub_btn_n(subBtnN),
    .o_add_db_n (addDbN),
    .o_sub_db_n (subDbN),
    .o_add_req  (addReq),
    .o_sub_req  (subReq),
    .o_conflict (conflict)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let a released button debounce back and the FSMs return to idle.
  task automatic settle();
    addBtnN = 1'b1;
    subBtnN = 1'b1;
    repeat (14) step();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    addBtnN = 1'b1;
    subBtnN = 1'b1;
    repeat (3) step();
    checkCount++;
    if (addDbN !== 1'b1) $display("[TB] FAIL reset_add_db got %b want 1", addDbN);
    else passCount++;
    checkCount++;
    if (subDbN !== 1'b1) $display("[TB] FAIL reset_sub_db got %b want 1", subDbN);
    else passCount++;
    checkCount++;
    if (addReq !== 1'b0) $display("[TB] FAIL reset_add_req got %b want 0", addReq);
    else passCount++;
    checkCount++;
    if (subReq !== 1'b0) $display("[TB] FAIL reset_sub_req got %b want 0", subReq);
    else passCount++;
    checkCount++;
    if (conflict !== 1'b0) $display("[TB] FAIL reset_conflict got %b want 0", conflict);
    else passCount++;
    rst_n = 1'b1;
    step();
    step();
  endtask

  // Press add: db falls at edge DB+1, pulse after edge DB+2.
  task automatic test_first_press();
    logic subSeen;
    int   extra;
    subSeen = 1'b0;
    addBtnN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (subReq) subSeen = 1'b1;
      checkCount++;
      if (addDbN !== ((k >= DB + 1) ? 1'b0 : 1'b1))
        $display("[TB] FAIL first_add_db edge %0d got %b want %b", k, addDbN, (k >= DB + 1) ? 1'b0 : 1'b1);
      else passCount++;
      checkCount++;
      if (addReq !== ((k == DB + 2) ? 1'b1 : 1'b0))
        $display("[TB] FAIL first_add_req edge %0d got %b want %b", k, addReq, (k == DB + 2) ? 1'b1 : 1'b0);
      else passCount++;
    end
    checkCount++;
    if (subSeen !== 1'b0) $display("[TB] FAIL first_sub_quiet got %b want 0", subSeen);
    else passCount++;
    addBtnN = 1'b1;
    extra = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (addReq) extra++;
    end
    checkCount++;
    if (extra != 0) $display("[TB] FAIL first_release_pulses got %0d want 0", extra);
    else passCount++;
    checkCount++;
    if (addDbN !== 1'b1) $display("[TB] FAIL first_release_db got %b want 1", addDbN);
    else passCount++;
  endtask

  // A 3-cycle low glitch is shorter than the debounce window.
  task automatic test_glitch();
    int dbLow;
    int pulses;
    dbLow  = 0;
    pulses = 0;
    addBtnN = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) addBtnN = 1'b1;
      step();
      if (!addDbN) dbLow++;
      if (addReq) pulses++;
    end
    checkCount++;
    if (dbLow != 0) $display("[TB] FAIL glitch_db_low got %0d cycles want 0", dbLow);
    else passCount++;
    checkCount++;
    if (pulses != 0) $display("[TB] FAIL glitch_pulses got %0d want 0", pulses);
    else passCount++;
  endtask

  // Hold sub past its first pulse, release so that db rises between the
  // +52 and +60 repeat slots.
  task automatic test_repeat();
    int firstEdge;
    int offs[16];
    int nOffs;
    int dbRise;
    int addPulses;
    int expOffs[6];
    int nExp;
    expOffs = '{0, 20, 28, 36, 44, 52};
`ifdef AUTO_REPEAT_EN
    nExp = 6;
`else
    nExp = 1;
`endif
    firstEdge = -1;
    nOffs     = 0;
    dbRise    = -1;
    addPulses = 0;
    subBtnN   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (subReq && firstEdge < 0) begin
        firstEdge = k;
        break;
      end
    end
    checkCount++;
    if (firstEdge != DB + 2) $display("[TB] FAIL repeat_first_edge got %0d want %0d", firstEdge, DB + 2);
    else passCount++;
    offs[0] = 0;
    nOffs   = 1;
    for (int j = 1; j <= 70; j++) begin
      if (j == 51) subBtnN = 1'b1;
      step();
      if (subReq) begin
        if (nOffs < 16) offs[nOffs] = j;
        nOffs++;
      end
      if (addReq) addPulses++;
      if (subDbN && dbRise < 0) dbRise = j;
    end
    checkCount++;
    if (nOffs != nExp) $display("[TB] FAIL repeat_count got %0d want %0d", nOffs, nExp);
    else passCount++;
    for (int i = 0; i < nExp && i < nOffs && i < 16; i++) begin
      checkCount++;
      if (offs[i] != expOffs[i]) $display("[TB] FAIL repeat_offset[%0d] got %0d want %0d", i, offs[i], expOffs[i]);
      else passCount++;
    end
    checkCount++;
    if (dbRise != 56) $display("[TB] FAIL repeat_db_rise got %0d want 56", dbRise);
    else passCount++;
    checkCount++;
    if (addPulses != 0) $display("[TB] FAIL repeat_add_quiet got %0d want 0", addPulses);
    else passCount++;
    settle();
  endtask

  // Add held, sub joins 10 cycles after add's first pulse.
  task automatic test_conflict();
    int found;
    int pulses;
    int conflictOn;
    int conflictOff;
    int dropped;
    int newFirst;
    found      = 0;
    pulses     = 0;
    conflictOn = -1;
    addBtnN    = 1'b0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (addReq) found = 1;
    end
    checkCount++;
    if (found != 1) $display("[TB] FAIL conflict_first_pulse got %0d want 1", found);
    else passCount++;
    for (int j = 1; j <= 40; j++) begin
      if (j == 11) subBtnN = 1'b0;
      step();
      if (addReq || subReq) pulses++;
      if (conflict && conflictOn < 0) conflictOn = j;
    end
    checkCount++;
    if (pulses != 0) $display("[TB] FAIL conflict_locked_pulses got %0d want 0", pulses);
    else passCount++;
    checkCount++;
    if (conflictOn != 17) $display("[TB] FAIL conflict_on_edge got %0d want 17", conflictOn);
    else passCount++;
    checkCount++;
    if (subDbN !== 1'b0) $display("[TB] FAIL conflict_sub_db got %b want 0", subDbN);
    else passCount++;
    subBtnN = 1'b1;
    pulses  = 0;
    dropped = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (addReq || subReq) pulses++;
      if (!conflict) dropped++;
    end
    checkCount++;
    if (pulses != 0) $display("[TB] FAIL conflict_partner_release_pulses got %0d want 0", pulses);
    else passCount++;
    checkCount++;
    if (dropped != 0) $display("[TB] FAIL conflict_held_low got %0d cycles want 0", dropped);
    else passCount++;
    checkCount++;
    if (subDbN !== 1'b1) $display("[TB] FAIL conflict_sub_released got %b want 1", subDbN);
    else passCount++;
    addBtnN     = 1'b1;
    conflictOff = -1;
    pulses      = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (addReq || subReq) pulses++;
      if (!conflict && conflictOff < 0) conflictOff = k;
    end
    checkCount++;
    if (conflictOff != DB + 2) $display("[TB] FAIL conflict_off_edge got %0d want %0d", conflictOff, DB + 2);
    else passCount++;
    checkCount++;
    if (pulses != 0) $display("[TB] FAIL conflict_exit_pulses got %0d want 0", pulses);
    else passCount++;
    addBtnN  = 1'b0;
    newFirst = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (addReq && newFirst < 0) newFirst = k;
    end
    checkCount++;
    if (newFirst != DB + 2) $display("[TB] FAIL conflict_new_press_edge got %0d want %0d", newFirst, DB + 2);
    else passCount++;
    settle();
  endtask

  // Both buttons debounce on the same edge: LOCK with no pulse.
  task automatic test_simultaneous();
    int pulses;
    int conflictOn;
    int conflictOff;
    pulses     = 0;
    conflictOn = -1;
    addBtnN    = 1'b0;
    subBtnN    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (addReq || subReq) pulses++;
      if (conflict && conflictOn < 0) conflictOn = k;
    end
    checkCount++;
    if (pulses != 0) $display("[TB] FAIL simul_pulses got %0d want 0", pulses);
    else passCount++;
    checkCount++;
    if (conflictOn != DB + 2) $display("[TB] FAIL simul_conflict_on got %0d want %0d", conflictOn, DB + 2);
    else passCount++;
    addBtnN     = 1'b1;
    subBtnN     = 1'b1;
    conflictOff = -1;
    pulses      = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (addReq || subReq) pulses++;
      if (!conflict && conflictOff < 0) conflictOff = k;
    end
    checkCount++;
    if (conflictOff != DB + 2) $display("[TB] FAIL simul_conflict_off got %0d want %0d", conflictOff, DB + 2);
    else passCount++;
    checkCount++;
    if (pulses != 0) $display("[TB] FAIL simul_release_pulses got %0d want 0", pulses);
    else passCount++;
  endtask

  // Reset asserted 28 cycles after the first pulse, when the repeat build
  // has a pulse on the output.
  task automatic test_reset_mid();
    int found;
    int firstIdx;
    found   = 0;
    addBtnN = 1'b0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (addReq) found = 1;
    end
    checkCount++;
    if (found != 1) $display("[TB] FAIL rstmid_first_pulse got %0d want 1", found);
    else passCount++;
    repeat (RD + RR) step();
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (addReq !== 1'b0) $display("[TB] FAIL rstmid_add_req got %b want 0", addReq);
    else passCount++;
    checkCount++;
    if (addDbN !== 1'b1) $display("[TB] FAIL rstmid_add_db got %b want 1", addDbN);
    else passCount++;
    checkCount++;
    if (conflict !== 1'b0) $display("[TB] FAIL rstmid_conflict got %b want 0", conflict);
    else passCount++;
    step();
    step();
    rst_n    = 1'b1;
    firstIdx = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (addReq && firstIdx < 0) firstIdx = k;
    end
    checkCount++;
    if (firstIdx != DB + 2) $display("[TB] FAIL rstmid_fresh_pulse_edge got %0d want %0d", firstIdx, DB + 2);
    else passCount++;
    settle();
  endtask

  // Hold add for 100 edges and count pulses.
  task automatic test_hold_long();
    int pulses;
    int expPulses;
`ifdef AUTO_REPEAT_EN
    expPulses = 11;
`else
    expPulses = 1;
`endif
    pulses  = 0;
    addBtnN = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (addReq) pulses++;
      checkCount++;
      if (addReq && subReq) $display("[TB] FAIL hold_both_req edge %0d got 1 want 0", k);
      else passCount++;
    end
    checkCount++;
    if (pulses != expPulses) $display("[TB] FAIL hold_pulse_count got %0d want %0d", pulses, expPulses);
    else passCount++;
    settle();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    addBtnN    = 1'b1;
    subBtnN    = 1'b1;
    test_reset();
    test_first_press();
    test_glitch();
    test_repeat();
    test_conflict();
    test_simultaneous();
    test_reset_mid();
    test_hold_long();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
